// File: rtl/display_pkg.sv
// Shared display types for the arbiter, its sources
// and the seven-segment scan controller.
package display_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [3:0] digit_t;
  typedef digit_t [0:NUM_DIGITS-1] frame_t;

  typedef enum logic {
    IDLE,
    HOLD
  } arb_state_t;

endpackage

// File: rtl/display_arbiter_if.sv
// Request/frame bundle from the sources and the
// granted frame bundle towards the scan controller.
interface display_arbiter_if
  import display_pkg::*;
#(
  parameter int N_REQ = 4
);

  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]         req;
  frame_t [N_REQ-1:0]       frame_in;
  logic [N_REQ-1:0]         grant;
  logic [IDW-1:0]           active_id;
  frame_t                   digits_out;
  logic                     valid_out;

  modport master (
    output req,
    output frame_in,
    input  grant,
    input  active_id,
    input  digits_out,
    input  valid_out
  );

  modport slave (
    input  req,
    input  frame_in,
    output grant,
    output active_id,
    output digits_out,
    output valid_out
  );

endinterface

// File: rtl/display_arbiter_rr.sv
// Combinational rotating-priority picker: scan from
// ptr_i with wrap, ignoring requesters in excl_i.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   ptr_i,
  input  logic [N_REQ-1:0] excl_i,
  output logic [N_REQ-1:0] winner_o,
  output logic [IDW-1:0]   idx_o,
  output logic             found_o
);

  logic [N_REQ-1:0] masked;
  logic             hit;
  int               k;

  assign masked = req_i & ~excl_i;

  always_comb begin
    winner_o = '0;
    idx_o    = '0;
    hit      = 1'b0;
    k        = 0;
    for (int off = 0; off < N_REQ; off++) begin
      k = int'(ptr_i) + off;
      if (k >= N_REQ) k = k - N_REQ;
      if (!hit && masked[k]) begin
        hit         = 1'b1;
        idx_o       = IDW'(k);
        winner_o[k] = 1'b1;
      end
    end
  end

  assign found_o = hit;

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the 8-digit display with a
// minimum dwell per grant; forwards the owner's frame.
module display_arbiter
  import display_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  display_arbiter_if.slave bus
);

  localparam int IDW   = $clog2(N_REQ);
  localparam int CNT_W =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD =
    CNT_W'(HOLD_CYCLES - 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]   id_q, id_d;
  frame_t           digits_q, digits_d;
  logic             valid_q, valid_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0] timer_q, timer_d;

  logic             release_w;
  logic [N_REQ-1:0] excl;
  logic [N_REQ-1:0] win;
  logic [IDW-1:0]   win_idx;
  logic             found;
  logic             take;

  // A releasing owner must not win its own re-pick.
  assign release_w = (state_q == HOLD) && !bus.req[id_q];
  assign excl      = release_w ? grant_q : '0;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .excl_i   (excl),
    .winner_o (win),
    .idx_o    (win_idx),
    .found_o  (found)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    id_d     = id_q;
    digits_d = digits_q;
    valid_d  = valid_q;
    ptr_d    = ptr_q;
    timer_d  = timer_q;
    take     = 1'b0;
    unique case (state_q)
      IDLE: take = found;
      HOLD: begin
        digits_d = bus.frame_in[id_q];
        if (release_w) begin
          if (found) begin
            take = 1'b1;
          end else begin
            state_d  = IDLE;
            grant_d  = '0;
            id_d     = '0;
            digits_d = '0;
            valid_d  = 1'b0;
            timer_d  = '0;
          end
        end else if (timer_q == '0) begin
          take = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d  = HOLD;
      grant_d  = win;
      id_d     = win_idx;
      digits_d = bus.frame_in[win_idx];
      valid_d  = 1'b1;
      timer_d  = RELOAD;
      ptr_d    = (win_idx == IDW'(N_REQ - 1)) ?
                 '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      id_q     <= '0;
      digits_q <= '0;
      valid_q  <= 1'b0;
      ptr_q    <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      id_q     <= id_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      ptr_q    <= ptr_d;
      timer_q  <= timer_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.active_id  = id_q;
  assign bus.digits_out = digits_q;
  assign bus.valid_out  = valid_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench: each step queues the expected
// post-edge outputs; a monitor pops and compares.
module tb_display_arbiter;
  import display_pkg::*;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
    frame_t     d;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  frame_t F [4];
  exp_t   expq [$];
  int     compared = 0;
  int     mismatched = 0;
  int     nstep = 0;

  display_arbiter_if #(.N_REQ(4)) bus ();

  display_arbiter #(
    .N_REQ       (4),
    .HOLD_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] oh2idx(
    input logic [3:0] g
  );
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++)
      if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic step(
    input logic       r,
    input logic [3:0] rq,
    input logic [3:0] eg
  );
    exp_t e;
    reset   = r;
    bus.req = rq;
    for (int i = 0; i < 4; i++)
      bus.frame_in[i] = F[i];
    e.g  = eg;
    e.id = oh2idx(eg);
    e.v  = |eg;
    e.d  = (|eg) ? F[oh2idx(eg)] : '0;
    expq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    exp_t a;
    int   n;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a.g  = bus.grant;
        a.id = bus.active_id;
        a.v  = bus.valid_out;
        a.d  = bus.digits_out;
        n++;
        compared++;
        if (a !== e) begin
          mismatched++;
          $display("FAIL step%0d: got g=%b id=%0d v=%b d=%h, want g=%b id=%0d v=%b d=%h",
                   n, a.g, a.id, a.v, a.d,
                   e.g, e.id, e.v, e.d);
        end
      end
    end
  end

  initial begin : stim
    F[0] = 32'hA0A0_0001;
    F[1] = 32'hB1B1_0002;
    F[2] = 32'h1234_5678;
    F[3] = 32'hD3D3_0004;
    bus.req = '0;
    for (int i = 0; i < 4; i++)
      bus.frame_in[i] = F[i];
    @(posedge clk);
    #2;

    // reset with all requesting
    step(1'b1, 4'b1111, 4'b0000);
    step(1'b1, 4'b1111, 4'b0000);

    // single request, held past expiry
    for (int i = 0; i < 6; i++)
      step(1'b0, 4'b0100, 4'b0100);
    step(1'b0, 4'b0000, 4'b0000);

    // rotation from pointer 0
    step(1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++)
      step(1'b0, 4'b1011, 4'b0001);
    for (int i = 0; i < 4; i++)
      step(1'b0, 4'b1011, 4'b0010);
    for (int i = 0; i < 4; i++)
      step(1'b0, 4'b1011, 4'b1000);
    step(1'b0, 4'b1011, 4'b0001);

    // early release hands over with fresh dwell
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b0011, 4'b0001);
    step(1'b0, 4'b0011, 4'b0001);
    for (int i = 0; i < 4; i++)
      step(1'b0, 4'b0010, 4'b0010);
    step(1'b0, 4'b0011, 4'b0001);
    step(1'b0, 4'b0000, 4'b0000);

    // sole requester, live frame change
    for (int i = 0; i < 20; i++) begin
      if (i == 10) F[0] = 32'hBEEF_0042;
      step(1'b0, 4'b0001, 4'b0001);
    end

    // reset mid-hold, then single grant and release
    step(1'b1, 4'b0001, 4'b0000);
    step(1'b0, 4'b1000, 4'b1000);
    step(1'b0, 4'b1000, 4'b1000);
    step(1'b0, 4'b0000, 4'b0000);
    step(1'b0, 4'b0000, 4'b0000);

    @(posedge clk);
    #2;
    compared++;
    if (expq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d left, want 0",
               expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
